// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between NUM_REQ byte sources.
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module uart_tx_arbiter #(
   parameter int Width_M      = 8,
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*Width_M-1:0]   req_data,
   output logic [NUM_REQ-1:0]           req_ack,
   input  logic                         cfg_par_en,
   input  logic                         cfg_par_type,
   input  logic                         Busy,
   output logic [Width_M-1:0]           P_DATA,
   output logic                         Data_Valid,
   output logic                         PAR_EN,
   output logic                         PAR_TYPE,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         active,
   output logic                         err_timeout
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

   state_t              r_state;
   logic [Width_M-1:0]  r_p_data;
   logic                r_data_valid;
   logic                r_par_en;
   logic                r_par_type;
   logic [NUM_REQ-1:0]  r_req_ack;
   logic [GW-1:0]       r_grant_id;
   logic                r_active;
   logic                r_err_timeout;
   logic [CW-1:0]       r_cnt;

   logic                w_any;
   logic [GW-1:0]       w_win;

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
      // Descending scan so the lowest valid index is the last (winning) assignment.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[GW'(k)]) begin
            w_any = 1'b1;
            w_win = GW'(k);
         end
      end
`else
      // Search starts one past the last grant and wraps.
      for (int k = 1; k <= NUM_REQ; k++) begin
         logic [GW-1:0] w_sel;
         w_sel = GW'((int'(r_grant_id) + k) % NUM_REQ);
         if (!w_any && req_valid[w_sel]) begin
            w_any = 1'b1;
            w_win = w_sel;
         end
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state       <= IDLE;
         r_p_data      <= '0;
         r_data_valid  <= 1'b0;
         r_par_en      <= 1'b0;
         r_par_type    <= 1'b0;
         r_req_ack     <= '0;
         r_grant_id    <= GW'(NUM_REQ - 1);
         r_active      <= 1'b0;
         r_err_timeout <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_data_valid  <= 1'b0;
         r_req_ack     <= '0;
         r_err_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any && !Busy) begin
                  r_p_data     <= req_data[int'(w_win)*Width_M +: Width_M];
                  r_par_en     <= cfg_par_en;
                  r_par_type   <= cfg_par_type;
                  r_grant_id   <= w_win;
                  r_active     <= 1'b1;
                  r_data_valid <= 1'b1;
                  r_req_ack    <= NUM_REQ'(1) << w_win;
                  r_state      <= LOAD;
               end
            end
            LOAD: begin
               r_cnt   <= '0;
               r_state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (Busy) begin
                  r_state <= WAIT_DONE;
               end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                  // Frame is dropped; the pointer already moved, so no retry.
                  r_err_timeout <= 1'b1;
                  r_active      <= 1'b0;
                  r_state       <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!Busy) begin
                  r_active <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign P_DATA      = r_p_data;
   assign Data_Valid  = r_data_valid;
   assign PAR_EN      = r_par_en;
   assign PAR_TYPE    = r_par_type;
   assign req_ack     = r_req_ack;
   assign grant_id    = r_grant_id;
   assign active      = r_active;
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit data, BUSY_TIMEOUT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic        cfg_par_en;
   logic        cfg_par_type;
   logic        Busy;
   logic [7:0]  P_DATA;
   logic        Data_Valid;
   logic        PAR_EN;
   logic        PAR_TYPE;
   logic [1:0]  grant_id;
   logic        active;
   logic        err_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_cnt [4];

   uart_tx_arbiter #(.Width_M(8), .NUM_REQ(4), .BUSY_TIMEOUT(4)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
      .cfg_par_en(cfg_par_en), .cfg_par_type(cfg_par_type), .Busy(Busy), .P_DATA(P_DATA),
      .Data_Valid(Data_Valid), .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE), .grant_id(grant_id),
      .active(active), .err_timeout(err_timeout)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b0; req_valid = '0; Busy = 1'b0;
      repeat (2) tick();
      RST = 1'b1;
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
   endtask

   task automatic wait_dv();
      for (int i = 0; i < 20; i++) begin
         if (Data_Valid) return;
         tick();
      end
      check("dv_wait_timeout", 32'(Data_Valid), 32'd1);
   endtask

   // One frame: Data_Valid/ack checks, Busy high for busy_len cycles, then active must drop.
   task automatic run_frame(input string tag, input int exp_id, input logic [7:0] exp_data,
                            input logic exp_pe, input logic exp_pt, input int busy_len,
                            input logic [3:0] next_valid);
      wait_dv();
      check({tag, "_dv"},    32'(Data_Valid), 32'd1);
      check({tag, "_gid"},   32'(grant_id),   32'(exp_id));
      check({tag, "_data"},  32'(P_DATA),     32'(exp_data));
      check({tag, "_pe"},    32'(PAR_EN),     32'(exp_pe));
      check({tag, "_pt"},    32'(PAR_TYPE),   32'(exp_pt));
      check({tag, "_ack"},   32'(req_ack),    32'(4'b0001 << exp_id));
      for (int i = 0; i < 4; i++) if (req_ack[i]) ack_cnt[i]++;
      req_valid = next_valid;
      tick();
      check({tag, "_dv_one"}, 32'(Data_Valid), 32'd0);
      Busy = 1'b1;
      repeat (busy_len) tick();
      Busy = 1'b0;
      check({tag, "_act_m"},  32'(active), 32'd1);
      tick();
      check({tag, "_act_m1"}, 32'(active), 32'd0);
      check({tag, "_gap"},    32'(Data_Valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      req_data = '0; cfg_par_en = 1'b0; cfg_par_type = 1'b0;
      do_reset();

      check("rst_data",  32'(P_DATA),      32'h0);
      check("rst_dv",    32'(Data_Valid),  32'd0);
      check("rst_pe",    32'(PAR_EN),      32'd0);
      check("rst_pt",    32'(PAR_TYPE),    32'd0);
      check("rst_ack",   32'(req_ack),     32'd0);
      check("rst_act",   32'(active),      32'd0);
      check("rst_err",   32'(err_timeout), 32'd0);
      check("rst_gid",   32'(grant_id),    32'd3);

      // Single requester
      req_data = 32'h0000_00A5; cfg_par_en = 1'b1; cfg_par_type = 1'b0;
      req_valid = 4'b0001;
      run_frame("single", 0, 8'hA5, 1'b1, 1'b0, 3, 4'b0000);

`ifdef UART_ARB_FIXED_PRIO_EN
      do_reset();
      req_data = 32'h0099_0077; cfg_par_en = 1'b0; cfg_par_type = 1'b1;
      req_valid = 4'b0101;
      for (int f = 0; f < 4; f++) run_frame("fixed", 0, 8'h77, 1'b0, 1'b1, 2, 4'b0101);
      check("fixed_ack0", 32'(ack_cnt[0]), 32'd4);
      check("fixed_ack2", 32'(ack_cnt[2]), 32'd0);
`else
      // Round-robin fairness over 8 frames
      do_reset();
      req_data = 32'h1312_1110; cfg_par_en = 1'b0; cfg_par_type = 1'b1;
      req_valid = 4'b1111;
      for (int f = 0; f < 8; f++)
         run_frame("rr", f % 4, 8'h10 + 8'(f % 4), 1'b0, 1'b1, 2, 4'b1111);
      for (int i = 0; i < 4; i++) check("rr_ack_count", 32'(ack_cnt[i]), 32'd2);

      // Mid-frame change of req_data / cfg_par_type while in WAIT_DONE
      req_valid = 4'b0010; req_data = 32'h0000_5A00; cfg_par_en = 1'b1; cfg_par_type = 1'b1;
      wait_dv();
      check("mid_gid",  32'(grant_id), 32'd1);
      check("mid_data", 32'(P_DATA),   32'h5A);
      tick();
      Busy = 1'b1;
      tick();
      req_data = 32'h0000_C300; cfg_par_type = 1'b0;
      tick();
      check("mid_hold_data", 32'(P_DATA),   32'h5A);
      check("mid_hold_pt",   32'(PAR_TYPE), 32'd1);
      tick();
      check("mid_hold_data2", 32'(P_DATA), 32'h5A);
      Busy = 1'b0;
      tick();
      run_frame("mid_next", 1, 8'hC3, 1'b1, 1'b0, 1, 4'b1100);

      // Timeout: requester 2 granted, Busy never rises
      req_data = 32'h3322_0000;
      wait_dv();
      check("to_gid", 32'(grant_id), 32'd2);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("to_err_early", 32'(err_timeout), 32'd0);
         check("to_act_hold",  32'(active),      32'd1);
      end
      tick();
      check("to_err_pulse", 32'(err_timeout), 32'd1);
      check("to_act_clr",   32'(active),      32'd0);
      tick();
      check("to_err_one",  32'(err_timeout), 32'd0);
      check("to_next_dv",  32'(Data_Valid),  32'd1);
      check("to_next_gid", 32'(grant_id),    32'd3);
      check("to_next_dat", 32'(P_DATA),      32'h33);
      req_valid = 4'b0000;

      // Reset asserted during WAIT_DONE
      tick();
      Busy = 1'b1;
      tick();
      check("wd_active", 32'(active), 32'd1);
      #2 RST = 1'b0;
      #1;
      check("arst_data", 32'(P_DATA),      32'h0);
      check("arst_dv",   32'(Data_Valid),  32'd0);
      check("arst_ack",  32'(req_ack),     32'd0);
      check("arst_act",  32'(active),      32'd0);
      check("arst_pe",   32'(PAR_EN),      32'd0);
      check("arst_pt",   32'(PAR_TYPE),    32'd0);
      check("arst_gid",  32'(grant_id),    32'd3);
      Busy = 1'b0; req_valid = 4'b1111; req_data = 32'h1312_1110;
      tick();
      RST = 1'b1;
      run_frame("post_rst", 0, 8'h10, 1'b1, 1'b0, 1, 4'b0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
